// File: rtl/rc5_arbiter.sv
// rc5_arbiter: two-port round-robin arbiter and sequencer for a shared rc5 core.
// Grants one job at a time, loads the key when needed, starts the core, waits
// for completion (bounded by a watchdog) and returns the result to the owner.
// Optional feature: define RC5_ARB_KEY_CACHE_EN to skip reloading an unchanged
// key/rounds pair.
module rc5_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int TW      = $clog2(TIMEOUT+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_op,
  input  logic [127:0] req0_key,
  input  logic [4:0]   req0_rounds,
  input  logic [31:0]  req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_op,
  input  logic [127:0] req1_key,
  input  logic [4:0]   req1_rounds,
  input  logic [31:0]  req1_data,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [31:0]  rsp0_data,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [31:0]  rsp1_data,
  output logic         rsp1_err,
  output logic         core_load_key,
  output logic         core_start_encrypt,
  output logic         core_start_decrypt,
  output logic [127:0] core_key,
  output logic [4:0]   core_num_rounds,
  output logic [31:0]  core_d_in,
  input  logic         core_key_ready,
  input  logic         core_done,
  input  logic [31:0]  core_d_out,
  output logic         busy,
  output logic         grant_id
);

  typedef enum logic [2:0] {IDLE, LOAD, KWAIT, START, RUN, RESP} state_t;

  state_t         state, state_nx;
  logic           last_grant;
  logic           op_q;
  logic [127:0]   key_q;
  logic [4:0]     rounds_q;
  logic [31:0]    din_q;
  logic [31:0]    rsp_data_q;
  logic           rsp_err_q;
  logic [TW-1:0]  wd_cnt;

  logic           any_req, sel, accept, hit;
  logic           wd_expire, key_ok, abort, rsp_take;
  logic [127:0]   sel_key;
  logic [4:0]     sel_rounds;

  // Round-robin pick: a lone requester wins; on a tie the one not served last.
  always_comb begin
    any_req    = req0_valid | req1_valid;
    sel        = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    accept     = (state == IDLE) && any_req && !rst;
    req0_ready = accept && !sel;
    req1_ready = accept && sel;
    sel_key    = sel ? req1_key    : req0_key;
    sel_rounds = sel ? req1_rounds : req0_rounds;
  end

  // Watchdog and status qualifiers. key_ready in the first KWAIT cycle
  // (count 0) may be stale from the previous key, so it is not trusted.
  always_comb begin
    wd_expire = (wd_cnt == TW'(TIMEOUT-1));
    key_ok    = core_key_ready && (wd_cnt != '0);
    abort     = ((state == KWAIT) && !key_ok && wd_expire) ||
                ((state == RUN) && !core_done && wd_expire);
    rsp_take  = (state == RESP) && (grant_id ? rsp1_ready : rsp0_ready);
  end

`ifdef RC5_ARB_KEY_CACHE_EN
  logic [127:0] cache_key;
  logic [4:0]   cache_rounds;
  logic         cache_vld;

  assign hit = cache_vld && (cache_key == sel_key) && (cache_rounds == sel_rounds);

  // Cache records the key once the core confirms it; any abort distrusts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld    <= 1'b0;
      cache_key    <= '0;
      cache_rounds <= '0;
    end else if ((state == KWAIT) && key_ok) begin
      cache_vld    <= 1'b1;
      cache_key    <= key_q;
      cache_rounds <= rounds_q;
    end else if (abort) begin
      cache_vld    <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and core pulse decode.
  always_comb begin
    state_nx           = state;
    core_load_key      = 1'b0;
    core_start_encrypt = 1'b0;
    core_start_decrypt = 1'b0;
    busy               = (state != IDLE);
    case (state)
      IDLE:  if (accept) state_nx = hit ? START : LOAD;
      LOAD: begin
        core_load_key = 1'b1;
        state_nx      = KWAIT;
      end
      KWAIT: begin
        if (key_ok)         state_nx = START;
        else if (wd_expire) state_nx = RESP;
      end
      START: begin
        core_start_encrypt = !op_q;
        core_start_decrypt = op_q;
        state_nx           = RUN;
      end
      RUN:   if (core_done || wd_expire) state_nx = RESP;
      RESP:  if (rsp_take) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Job operands, ownership and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      op_q       <= 1'b0;
      key_q      <= '0;
      rounds_q   <= '0;
      din_q      <= '0;
    end else begin
      if (accept) begin
        grant_id <= sel;
        op_q     <= sel ? req1_op   : req0_op;
        key_q    <= sel_key;
        rounds_q <= sel_rounds;
        din_q    <= sel ? req1_data : req0_data;
      end
      if (rsp_take) last_grant <= grant_id;
    end
  end

  // Result capture; a completion in the expiry cycle still counts as success.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if ((state == RUN) && core_done) begin
      rsp_data_q <= core_d_out;
      rsp_err_q  <= 1'b0;
    end else if (abort) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b1;
    end
  end

  // Watchdog: cleared in the cycle before KWAIT/RUN, counts while in them.
  always_ff @(posedge clk) begin
    if (rst)                                  wd_cnt <= '0;
    else if (state == LOAD || state == START) wd_cnt <= '0;
    else if (state == KWAIT || state == RUN)  wd_cnt <= wd_cnt + TW'(1);
  end

  assign core_key        = key_q;
  assign core_num_rounds = rounds_q;
  assign core_d_in       = din_q;

  assign rsp0_valid = (state == RESP) && !grant_id;
  assign rsp1_valid = (state == RESP) && grant_id;
  assign rsp0_data  = rsp0_valid ? rsp_data_q : '0;
  assign rsp1_data  = rsp1_valid ? rsp_data_q : '0;
  assign rsp0_err   = rsp0_valid && rsp_err_q;
  assign rsp1_err   = rsp1_valid && rsp_err_q;

endmodule

// File: tb/tb_rc5_arbiter.sv
// tb_rc5_arbiter: directed bench with a behavioural core, a timeline-based
// reference model checked every cycle, and hand-computed literal checks.
module tb_rc5_arbiter;
  localparam int TO = 8;
`ifdef RC5_ARB_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [127:0] K = 128'h2B7E151628AED2A6ABF7158809CF4F3C;

  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req0_ready, req0_op = 0;
  logic [127:0] req0_key = '0; logic [4:0] req0_rounds = '0; logic [31:0] req0_data = '0;
  logic req1_valid = 0, req1_ready, req1_op = 0;
  logic [127:0] req1_key = '0; logic [4:0] req1_rounds = '0; logic [31:0] req1_data = '0;
  logic rsp0_valid, rsp0_ready = 1, rsp0_err; logic [31:0] rsp0_data;
  logic rsp1_valid, rsp1_ready = 1, rsp1_err; logic [31:0] rsp1_data;
  logic core_load_key, core_start_encrypt, core_start_decrypt;
  logic [127:0] core_key; logic [4:0] core_num_rounds; logic [31:0] core_d_in;
  logic core_key_ready, core_done; logic [31:0] core_d_out;
  logic busy, grant_id;

  rc5_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_key(req0_key), .req0_rounds(req0_rounds), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_key(req1_key), .req1_rounds(req1_rounds), .req1_data(req1_data),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .core_load_key(core_load_key), .core_start_encrypt(core_start_encrypt),
    .core_start_decrypt(core_start_decrypt), .core_key(core_key),
    .core_num_rounds(core_num_rounds), .core_d_in(core_d_in),
    .core_key_ready(core_key_ready), .core_done(core_done), .core_d_out(core_d_out),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Toy reversible cipher standing in for rc5.
  function automatic logic [31:0] toy(input logic op, input logic [127:0] k,
                                      input logic [4:0] r, input logic [31:0] d);
    return op ? ((d - 32'(r)) ^ k[31:0]) : ((d ^ k[31:0]) + 32'(r));
  endfunction

  // Behavioural core: key_ready stays stale for one cycle after a load, then
  // rises tkey cycles later; done pulses in RUN cycle tdone+1 unless hung.
  int tkey = 2, tdone = 3; bit hang = 0;
  int kdly = 0, ddly = 0; logic [31:0] cres = '0;
  always @(posedge clk) begin
    if (rst) begin
      core_key_ready <= 0; core_done <= 0; kdly <= 0; ddly <= 0;
    end else begin
      if (core_load_key) kdly <= tkey;
      else if (kdly > 0) begin kdly <= kdly - 1; core_key_ready <= (kdly == 1); end
      if (core_start_encrypt || core_start_decrypt) begin
        ddly <= hang ? 0 : tdone; core_done <= 0;
        cres <= toy(core_start_decrypt, core_key, core_num_rounds, core_d_in);
      end else if (ddly > 0) begin ddly <= ddly - 1; core_done <= (ddly == 1); end
      else core_done <= 0;
    end
  end
  assign core_d_out = core_done ? cres : 32'hBADC0DE5;

  // Reference model: on accept, compute the whole job timeline up front.
  bit m_free = 1, m_last = 1, m_gnt = 0, m_op = 0, m_err = 0;
  logic [127:0] m_key = '0; logic [4:0] m_rnd = '0; logic [31:0] m_din = '0, m_rdata = '0;
  int t_load = -1, t_start = -1, t_resp = 0;
  bit c_vld = 0; logic [127:0] c_key = '0; logic [4:0] c_rnd = '0;

  function automatic bit pick();
    return (req0_valid && req1_valid) ? !m_last : req1_valid;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_free = 1; m_last = 1; m_gnt = 0; m_op = 0;
      m_key = '0; m_rnd = '0; m_din = '0; c_vld = 0;
    end else if (m_free) begin
      if (req0_valid || req1_valid) begin
        bit s, hit;
        s = pick();
        m_gnt = s; m_op = s ? req1_op : req0_op;
        m_key = s ? req1_key : req0_key; m_rnd = s ? req1_rounds : req0_rounds;
        m_din = s ? req1_data : req0_data;
        hit = CACHE && c_vld && (c_key == m_key) && (c_rnd == m_rnd);
        m_free = 0; m_err = 0; m_rdata = '0; t_load = -1; t_start = -1;
        if (hit) t_start = cyc + 1;
        else begin
          t_load = cyc + 1;
          if (tkey + 1 <= TO) begin
            t_start = cyc + 2 + tkey + 1; c_vld = 1; c_key = m_key; c_rnd = m_rnd;
          end else begin
            t_resp = cyc + 2 + TO; m_err = 1; c_vld = 0;
          end
        end
        if (t_start >= 0) begin
          if (!hang && tdone + 1 <= TO) begin
            t_resp = t_start + 1 + tdone + 1; m_rdata = toy(m_op, m_key, m_rnd, m_din);
          end else begin
            t_resp = t_start + 1 + TO; m_err = 1; c_vld = 0;
          end
        end
      end
    end else if (cyc >= t_resp && (m_gnt ? rsp1_ready : rsp0_ready)) begin
      m_free = 1; m_last = m_gnt;
    end
    cyc++;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit a, s, ev0, ev1;
      a = m_free && !rst && (req0_valid || req1_valid);
      s = pick();
      ev0 = !m_free && cyc >= t_resp && !m_gnt;
      ev1 = !m_free && cyc >= t_resp && m_gnt;
      chk("req0_ready", req0_ready, a && !s);
      chk("req1_ready", req1_ready, a && s);
      chk("busy", busy, !m_free);
      chk("grant_id", grant_id, m_gnt);
      chk("load_key", core_load_key, !m_free && cyc == t_load);
      chk("start_enc", core_start_encrypt, !m_free && cyc == t_start && !m_op);
      chk("start_dec", core_start_decrypt, !m_free && cyc == t_start && m_op);
      chk("core_key", core_key, m_key);
      chk("core_rounds", core_num_rounds, m_rnd);
      chk("core_d_in", core_d_in, m_din);
      chk("rsp0_valid", rsp0_valid, ev0);
      chk("rsp1_valid", rsp1_valid, ev1);
      chk("rsp0_data", rsp0_data, ev0 ? m_rdata : 32'h0);
      chk("rsp1_data", rsp1_data, ev1 ? m_rdata : 32'h0);
      chk("rsp0_err", rsp0_err, ev0 && m_err);
      chk("rsp1_err", rsp1_err, ev1 && m_err);
    end
  end

  // Pulse counters and observation helpers for the directed checks.
  int n_load = 0, n_enc = 0, n_dec = 0, st_cyc = 0;
  logic [31:0] done_data = '0;
  always @(negedge clk) begin
    if (core_load_key) n_load++;
    if (core_start_encrypt) begin n_enc++; st_cyc = cyc; end
    if (core_start_decrypt) begin n_dec++; st_cyc = cyc; end
    if (core_done) done_data = core_d_out;
  end

  task automatic set_req(input int n, input logic v, input logic op, input logic [127:0] k,
                         input logic [4:0] r, input logic [31:0] d);
    if (n == 0) begin req0_valid = v; req0_op = op; req0_key = k; req0_rounds = r; req0_data = d; end
    else begin req1_valid = v; req1_op = op; req1_key = k; req1_rounds = r; req1_data = d; end
  endtask

  task automatic clr_cnt();
    n_load = 0; n_enc = 0; n_dec = 0;
  endtask

  task automatic wait_acc(output int id, output int c);
    bit got = 0;
    id = -1; c = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin id = 0; c = cyc; got = 1; end
      else if (req1_valid && req1_ready) begin id = 1; c = cyc; got = 1; end
    end
    if (!got) begin tests++; fails++; $display("FAIL accept_wait: got none, expected accept"); end
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input int n, output logic [31:0] d, output logic e, output int c);
    bit got = 0;
    d = 'x; e = 1'bx; c = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (n == 0 && rsp0_valid && rsp0_ready) begin d = rsp0_data; e = rsp0_err; c = cyc; got = 1; end
      if (n == 1 && rsp1_valid && rsp1_ready) begin d = rsp1_data; e = rsp1_err; c = cyc; got = 1; end
    end
    if (!got) begin tests++; fails++; $display("FAIL rsp_wait: got none, expected response on port %0d", n); end
    @(posedge clk); #1;
  endtask

  initial begin
    int id, ca, cr, g;
    logic [31:0] d, d0;
    logic e, e0;
    bit got;

    repeat (3) @(posedge clk);
    #1 rst = 0; chk_en = 1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_data", rsp1_data, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_pulses", {core_load_key, core_start_encrypt, core_start_decrypt}, 0);
    @(posedge clk); #1;

    // Single encrypt
    clr_cnt();
    set_req(0, 1, 0, K, 5'd15, 32'hD87FAB42);
    wait_acc(id, ca); req0_valid = 0;
    wait_rsp(0, d, e, cr);
    chk("t1_grant", id, 0);
    chk("t1_data", d, 32'hD1B0E48D);
    chk("t1_err", e, 0);
    chk("t1_done_data", d, done_data);
    chk("t1_loads", n_load, 1);
    chk("t1_enc", n_enc, 1);
    chk("t1_dec", n_dec, 0);
    chk("t1_latency", cr - ca, 10);

    // Round trip on requester 1
    clr_cnt();
    set_req(1, 1, 1, K, 5'd15, 32'hD1B0E48D);
    wait_acc(id, ca); req1_valid = 0;
    wait_rsp(1, d, e, cr);
    chk("t2_grant", id, 1);
    chk("t2_data", d, 32'hD87FAB42);
    chk("t2_loads", n_load, CACHE ? 0 : 1);
    chk("t2_dec", n_dec, 1);
    chk("t2_latency", cr - ca, CACHE ? 6 : 10);

    // Contention: both valid for four jobs
    set_req(0, 1, 0, K, 5'd15, 32'h00000001);
    set_req(1, 1, 0, K, 5'd15, 32'h00000002);
    for (int k = 0; k < 4; k++) begin
      wait_acc(g, ca);
      if (k == 3) begin req0_valid = 0; req1_valid = 0; end
      chk("t3_grant", g, k % 2);
      wait_rsp(g, d, e, cr);
      chk("t3_data", d, (k % 2) ? 32'h09CF4F4D : 32'h09CF4F4C);
    end

    // Rounds change forces a reload
    clr_cnt();
    set_req(0, 1, 0, K, 5'd12, 32'hD87FAB42);
    wait_acc(id, ca); req0_valid = 0;
    wait_rsp(0, d, e, cr);
    chk("t4_data", d, 32'hD1B0E48A);
    chk("t4_loads", n_load, 1);

    // Watchdog on a hung core
    hang = 1;
    set_req(0, 1, 0, K, 5'd12, 32'h12345678);
    wait_acc(id, ca); req0_valid = 0;
    wait_rsp(0, d, e, cr);
    chk("t5_err", e, 1);
    chk("t5_data", d, 0);
    chk("t5_timeout", cr - st_cyc, 9);
    hang = 0;
    clr_cnt();
    set_req(0, 1, 0, K, 5'd12, 32'h12345678);
    wait_acc(id, ca); req0_valid = 0;
    wait_rsp(0, d, e, cr);
    chk("t6_loads", n_load, 1);
    chk("t6_data", d, 32'h1BFB1950);
    chk("t6_err", e, 0);

    // Backpressure on rsp0 with requester 1 waiting
    rsp0_ready = 0;
    set_req(0, 1, 0, K, 5'd12, 32'hD87FAB42);
    wait_acc(id, ca); req0_valid = 0;
    set_req(1, 1, 0, K, 5'd12, 32'h00000005);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rsp0_valid) got = 1;
    end
    chk("t7_valid_seen", got, 1);
    d0 = rsp0_data; e0 = rsp0_err;
    chk("t7_data", d0, 32'hD1B0E48A);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t7_hold_valid", rsp0_valid, 1);
      chk("t7_hold_data", rsp0_data, d0);
      chk("t7_hold_err", rsp0_err, e0);
      chk("t7_no_accept", req1_ready, 0);
    end
    @(posedge clk); #1 rsp0_ready = 1;
    wait_rsp(0, d, e, cr);
    wait_acc(id, ca); req1_valid = 0;
    chk("t7_next_grant", id, 1);
    wait_rsp(1, d, e, cr);
    chk("t7_data1", d, 32'h09CF4F45);

    // Reset mid-RUN
    set_req(0, 1, 1, K, 5'd15, 32'hCAFEF00D);
    wait_acc(id, ca); req0_valid = 0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (core_start_encrypt || core_start_decrypt) got = 1;
    end
    chk("t8_started", got, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t8_busy", busy, 0);
    chk("t8_grant", grant_id, 0);
    chk("t8_core_key", core_key, 0);
    chk("t8_rsp0", {rsp0_valid, rsp0_err, rsp0_data}, 0);
    chk("t8_pulses", {core_load_key, core_start_encrypt, core_start_decrypt}, 0);
    @(posedge clk); #1;
    clr_cnt();
    set_req(1, 1, 0, K, 5'd15, 32'hD87FAB42);
    wait_acc(id, ca); req1_valid = 0;
    wait_rsp(1, d, e, cr);
    chk("t8_reload", n_load, 1);
    chk("t8_data", d, 32'hD1B0E48D);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
